// File: rtl/alu_pkg.sv
// Shared encodings for the 6502-style ALU: one-hot op selects and the BCD fix-up constant.
package alu_pkg;

  localparam logic [4:0] SUMS = 5'b00001;
  localparam logic [4:0] ANDS = 5'b00010;
  localparam logic [4:0] ORS  = 5'b00100;
  localparam logic [4:0] EORS = 5'b01000;
  localparam logic [4:0] SRS  = 5'b10000;

  localparam logic [3:0] BCD_ADJ = 4'h6;

  // Request vector is {srs, eors, ors, ands, sums}; lowest bit wins when several are set.
  function automatic logic [4:0] op_pick(input logic [4:0] req);
    logic [4:0] sel;
    sel = '0;
    if (req[0])      sel = SUMS;
    else if (req[1]) sel = ANDS;
    else if (req[2]) sel = ORS;
    else if (req[3]) sel = EORS;
    else if (req[4]) sel = SRS;
    return sel;
  endfunction

endpackage

// File: rtl/alu_bcd_unit_bcd_adjust.sv
// Decimal-adjust stage: per-nibble +6 / -6 correction of the raw adder result, no inter-nibble carry.
module bcd_adjust
  import alu_pkg::*;
(
  input  logic       dsa,
  input  logic       daa,
  input  logic       hc,
  input  logic       acr,
  input  logic [7:0] sb,
  output logic [7:0] sb_ac
);

  logic [3:0] lo_n;
  logic [3:0] hi_n;

  always_comb begin
    lo_n = sb[3:0];
    hi_n = sb[7:4];
    if (daa) begin
      if (hc)  lo_n = sb[3:0] + BCD_ADJ;
      if (acr) hi_n = sb[7:4] + BCD_ADJ;
    end else if (dsa) begin
      if (!hc)  lo_n = sb[3:0] - BCD_ADJ;
      if (!acr) hi_n = sb[7:4] - BCD_ADJ;
    end
    sb_ac = {hi_n, lo_n};
  end

endmodule

// File: rtl/alu_bcd_unit.sv
// 8-bit NMOS-6502 ALU: binary core, decimal adjust, and a one-cycle output hold register.
module alu_bcd_unit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       i_addc,
  input  logic       daa,
  input  logic       dsa,
  input  logic       sums,
  input  logic       ands,
  input  logic       ors,
  input  logic       eors,
  input  logic       srs,
  output logic [7:0] sb,
  output logic [7:0] sb_ac,
  output logic       acr,
  output logic       hc,
  output logic       avr
);

  logic [4:0] op_sel;
  logic       is_sum;
  logic [4:0] lo;
  logic [4:0] hi;
  logic       hc_add;
  logic       acr_add;
  logic       avr_add;
  logic [7:0] res_sb;
  logic [7:0] res_sb_ac;
  logic       res_acr;
  logic       res_hc;
  logic       res_avr;

  assign op_sel = op_pick({srs, eors, ors, ands, sums});
  assign is_sum = (op_sel == SUMS);

  // In decimal add the nibble carries are the ">9" detects, chained into the high nibble.
  always_comb begin
    lo      = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, i_addc};
    hc_add  = daa ? (lo > 5'd9) : lo[4];
    hi      = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, hc_add};
    acr_add = daa ? (hi > 5'd9) : hi[4];
    avr_add = ~(a[7] ^ b[7]) & (a[7] ^ hi[3]);
  end

  always_comb begin
    res_sb  = '0;
    res_acr = 1'b0;
    res_hc  = 1'b0;
    res_avr = 1'b0;
    case (op_sel)
      SUMS: begin
        res_sb  = {hi[3:0], lo[3:0]};
        res_acr = acr_add;
        res_hc  = hc_add;
        res_avr = avr_add;
      end
      ANDS: res_sb = a & b;
      ORS:  res_sb = a | b;
      EORS: res_sb = a ^ b;
      SRS: begin
        res_sb  = {i_addc, a[7:1]};
        res_acr = a[0];
      end
      default: ;
    endcase
  end

  bcd_adjust u_bcd_adjust (
    .dsa   (dsa & is_sum),
    .daa   (daa & is_sum),
    .hc    (res_hc),
    .acr   (res_acr),
    .sb    (res_sb),
    .sb_ac (res_sb_ac)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb    <= '0;
      sb_ac <= '0;
      acr   <= 1'b0;
      hc    <= 1'b0;
      avr   <= 1'b0;
    end else begin
      sb    <= res_sb;
      sb_ac <= res_sb_ac;
      acr   <= res_acr;
      hc    <= res_hc;
      avr   <= res_avr;
    end
  end

endmodule

// File: tb/tb_alu_bcd_unit.sv
// Scoreboard bench for alu_bcd_unit: directed vectors with hand-computed results.
module tb_alu_bcd_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       i_addc = 1'b0, daa = 1'b0, dsa = 1'b0;
  logic       sums = 1'b0, ands = 1'b0, ors = 1'b0, eors = 1'b0, srs = 1'b0;
  logic [7:0] sb, sb_ac;
  logic       acr, hc, avr;

  typedef struct {
    int         id;
    logic [7:0] sb;
    logic [7:0] ac;
    logic       acr;
    logic       hc;
    logic       avr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;
  logic issued = 1'b0;
  logic chk_pending = 1'b0;

  alu_bcd_unit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .i_addc(i_addc), .daa(daa), .dsa(dsa),
    .sums(sums), .ands(ands), .ors(ors), .eors(eors), .srs(srs),
    .sb(sb), .sb_ac(sb_ac), .acr(acr), .hc(hc), .avr(avr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) chk_pending <= 1'b0;
    else     chk_pending <= issued;
  end

  // Monitor: a vector driven at one falling edge is captured on the next rising edge.
  always @(negedge clk) begin
    if (chk_pending) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: output presented with no expected entry");
      end else begin
        e = exp_q.pop_front();
        if (sb !== e.sb || sb_ac !== e.ac || acr !== e.acr || hc !== e.hc || avr !== e.avr) begin
          errors++;
          $display("FAIL vec%0d: got sb=%h sb_ac=%h acr=%b hc=%b avr=%b, want sb=%h sb_ac=%h acr=%b hc=%b avr=%b",
                   e.id, sb, sb_ac, acr, hc, avr, e.sb, e.ac, e.acr, e.hc, e.avr);
        end
      end
    end
  end

  task automatic apply(input logic [7:0] av, bv, input logic cv, dav, dsv, input logic [4:0] ops,
                       input logic [7:0] sb_e, ac_e, input logic acr_e, hc_e, avr_e);
    @(negedge clk);
    a = av; b = bv; i_addc = cv; daa = dav; dsa = dsv;
    {srs, eors, ors, ands, sums} = ops;
    exp_q.push_back('{vec_id, sb_e, ac_e, acr_e, hc_e, avr_e});
    vec_id++;
    issued = 1'b1;
  endtask

  task automatic hold_inputs();
    @(negedge clk);
    issued = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({sb, sb_ac, acr, hc, avr} !== 19'd0) begin
      errors++;
      $display("FAIL %s: got sb=%h sb_ac=%h acr=%b hc=%b avr=%b, want all zero", nm, sb, sb_ac, acr, hc, avr);
    end
  endtask

  // Assert reset asynchronously mid-cycle while a non-zero result is being held.
  task automatic reset_mid(input string nm);
    hold_inputs();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero(nm);
    #1 rst = 1'b0;
  endtask

  initial begin
    #7 check_zero("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    // binary add
    apply(8'h7f, 8'h01, 0, 0, 0, SUMS, 8'h80, 8'h80, 0, 1, 1);
    apply(8'hff, 8'h01, 0, 0, 0, SUMS, 8'h00, 8'h00, 1, 1, 0);
    apply(8'h80, 8'h80, 0, 0, 0, SUMS, 8'h00, 8'h00, 1, 0, 1);
    apply(8'h12, 8'h34, 1, 0, 0, SUMS, 8'h47, 8'h47, 0, 0, 0);
    apply(8'h0f, 8'h00, 1, 0, 0, SUMS, 8'h10, 8'h10, 0, 1, 0);
    // logic and shift
    apply(8'hf0, 8'h3c, 1, 0, 0, ANDS, 8'h30, 8'h30, 0, 0, 0);
    apply(8'ha5, 8'h0f, 0, 0, 0, ORS,  8'haf, 8'haf, 0, 0, 0);
    apply(8'hff, 8'h5a, 0, 0, 0, EORS, 8'ha5, 8'ha5, 0, 0, 0);
    apply(8'h03, 8'h00, 1, 0, 0, SRS,  8'h81, 8'h81, 1, 0, 0);
    apply(8'h80, 8'hff, 0, 0, 0, SRS,  8'h40, 8'h40, 0, 0, 0);
    apply(8'hff, 8'h00, 0, 0, 0, SRS,  8'h7f, 8'h7f, 1, 0, 0);
    // decimal add
    apply(8'h79, 8'h00, 1, 1, 0, SUMS, 8'h8a, 8'h80, 0, 1, 1);
    apply(8'h24, 8'h56, 0, 1, 0, SUMS, 8'h8a, 8'h80, 0, 1, 1);
    apply(8'h93, 8'h82, 0, 1, 0, SUMS, 8'h15, 8'h75, 1, 0, 1);
    apply(8'h89, 8'h76, 1, 1, 0, SUMS, 8'h00, 8'h66, 1, 1, 0);
    apply(8'h80, 8'hf0, 0, 1, 0, SUMS, 8'h70, 8'hd0, 1, 0, 1);
    apply(8'h80, 8'hfa, 0, 1, 0, SUMS, 8'h8a, 8'he0, 1, 1, 0);
    apply(8'h2f, 8'h4f, 0, 1, 0, SUMS, 8'h7e, 8'h74, 0, 1, 0);
    apply(8'h6f, 8'h00, 1, 1, 0, SUMS, 8'h70, 8'h76, 0, 1, 0);
    apply(8'h05, 8'h05, 0, 1, 0, SUMS, 8'h1a, 8'h10, 0, 1, 0);
    // decimal subtract (b is the complemented operand)
    apply(8'h00, 8'hff, 0, 0, 1, SUMS, 8'hff, 8'h99, 0, 0, 0);
    apply(8'h00, 8'hff, 1, 0, 1, SUMS, 8'h00, 8'h00, 1, 1, 0);
    apply(8'h00, 8'hfe, 1, 0, 1, SUMS, 8'hff, 8'h99, 0, 0, 0);
    apply(8'h0b, 8'hff, 0, 0, 1, SUMS, 8'h0a, 8'h0a, 1, 1, 0);
    apply(8'h9a, 8'hff, 1, 0, 1, SUMS, 8'h9a, 8'h9a, 1, 1, 0);
    apply(8'h10, 8'hfe, 1, 0, 1, SUMS, 8'h0f, 8'h09, 1, 0, 0);
    // op-select corners
    apply(8'h55, 8'h66, 1, 1, 0, 5'b00000, 8'h00, 8'h00, 0, 0, 0);
    apply(8'h12, 8'h34, 0, 0, 0, 5'b00011, 8'h46, 8'h46, 0, 0, 0);
    apply(8'h24, 8'h56, 0, 1, 1, SUMS, 8'h8a, 8'h80, 0, 1, 1);
    apply(8'h0a, 8'hff, 1, 1, 0, ANDS, 8'h0a, 8'h0a, 0, 0, 0);
    apply(8'h0f, 8'hf0, 0, 0, 1, 5'b01100, 8'hff, 8'hff, 0, 0, 0);
    apply(8'h03, 8'h01, 1, 0, 0, 5'b11000, 8'h02, 8'h02, 0, 0, 0);

    // reset while holding results with different flag sets, then first edge loads new result
    apply(8'h7f, 8'h01, 0, 0, 0, SUMS, 8'h80, 8'h80, 0, 1, 1);
    reset_mid("reset_mid_a");
    apply(8'h01, 8'h01, 0, 0, 0, SUMS, 8'h02, 8'h02, 0, 0, 0);
    apply(8'h80, 8'hf0, 0, 1, 0, SUMS, 8'h70, 8'hd0, 1, 0, 1);
    reset_mid("reset_mid_b");
    apply(8'h03, 8'h00, 1, 0, 0, SRS, 8'h81, 8'h81, 1, 0, 0);

    // latency: inputs change between edges, outputs must hold
    apply(8'h93, 8'h82, 0, 1, 0, SUMS, 8'h15, 8'h75, 1, 0, 1);
    @(posedge clk);
    #2 a = 8'h00; b = 8'h00; daa = 1'b0; sums = 1'b0; ands = 1'b1;
    #1 checks++;
    if (sb !== 8'h15 || sb_ac !== 8'h75 || acr !== 1'b1 || avr !== 1'b1) begin
      errors++;
      $display("FAIL latency_hold: got sb=%h sb_ac=%h acr=%b avr=%b, want sb=15 sb_ac=75 acr=1 avr=1",
               sb, sb_ac, acr, avr);
    end
    apply(8'h24, 8'h56, 0, 0, 0, SUMS, 8'h7a, 8'h7a, 0, 0, 0);
    hold_inputs();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected results never observed, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_bcd_unit.md
Name: alu_bcd_unit

Overview:
8-bit 6502-style arithmetic/logic unit with NMOS-accurate BCD (decimal) correction. It combines the binary ALU core (add, AND, OR, EOR, shift-right) with a decimal-adjust stage that corrects the adder result for ADC/SBC in decimal mode. The block sits in the CPU datapath between the A/B input latches and the special bus (SB). Results and flags are captured in an output hold register.

Parameters:
none (data width fixed at 8)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset; asynchronous, active-high
a  in  8  A operand
b  in  8  B operand; the caller presents ~operand for SBC
i_addc  in  1  carry in; shift-in bit for SR
daa  in  1  decimal add enable (ADC in D mode)
dsa  in  1  decimal subtract enable (SBC in D mode)
sums  in  1  op select: add
ands  in  1  op select: AND
ors  in  1  op select: OR
eors  in  1  op select: EOR
srs  in  1  op select: shift right
sb  out  8  registered raw adder/logic result, before decimal adjust
sb_ac  out  8  registered decimal-adjusted result (equals sb when not adjusting)
acr  out  1  registered carry out
hc  out  1  registered half carry (carry into bit 4)
avr  out  1  registered signed overflow

Behaviour:
- Async reset: sb, sb_ac, acr, hc and avr are all 0.
- Latency: 1 cycle. Inputs are sampled on the rising clk edge, and outputs hold until the next edge.
- Op selects are one-hot, with priority sums > ands > ors > eors > srs. When no select is active: result = 0x00 and all flags = 0.
- SUM, binary (daa=0):
  - lo = a[3:0] + b[3:0] + i_addc; hc = lo[4].
  - hi = a[7:4] + b[7:4] + hc; acr = hi[4].
  - sb = {hi[3:0], lo[3:0]}.
- SUM, daa=1:
  - hc = (lo > 9).
  - hi = a[7:4] + b[7:4] + hc; acr = (hi > 9).
  - sb nibbles are the same raw 4-bit sums as in binary mode.
- avr (SUM, both modes) = ~(a[7]^b[7]) & (a[7]^hi[3]), taken from the unadjusted high nibble.
- AND/OR/EOR: sb = a op b; acr = hc = avr = 0.
- SR: sb = {i_addc, a[7:1]}; acr = a[0]; hc = avr = 0.
- Decimal adjust applies only when sums is active. Each nibble is corrected independently and wraps mod 16, with no inter-nibble carry.
  - daa=1: low nibble += 6 if hc; high nibble += 6 if acr.
  - dsa=1 (and daa=0): low nibble -= 6 if !hc; high nibble -= 6 if !acr. Carries for dsa are the binary carries.
  - daa and dsa both 1: daa wins and dsa is ignored.
  - Neither set: sb_ac = sb.
- Flags are not modified by the adjust stage. acr and hc outputs are the adder values.
- Operands that are not valid BCD (e.g. 0x2f) follow the same rules exactly, with no saturation.

Decomposition:
- Package alu_pkg holds:
  - the one-hot op encodings: SUMS=5'b00001, ANDS=5'b00010, ORS=5'b00100, EORS=5'b01000, SRS=5'b10000;
  - the BCD correction constant 4'h6.
- Sub-module bcd_adjust: combinational, inputs (dsa, daa, hc, acr, sb), output sb_ac.
- The top level contains the combinational ALU core, the bcd_adjust instance and the output register.

Test Plan:
- Reset: assert rst mid-operation -> all outputs 0 immediately; first post-reset edge loads new result.
- Binary exhaustive: all a, b, i_addc for SUM/AND/OR/EOR/SR -> matches arithmetic model. Example: 0x7f+0x01 -> sb=0x80, avr=1, hc=1, acr=0; SR 0x03 with c=1 -> 0x81, acr=1.
- Decimal add, daa=1, result sb_ac / acr:
  - 0x79+0x00+1 -> 0x80 / 0
  - 0x24+0x56 -> 0x80 / 0
  - 0x93+0x82 -> 0x75 / 1
  - 0x89+0x76+1 -> 0x66 / 1
  - 0x80+0xf0 -> 0xd0 / 1
  - 0x80+0xfa -> 0xe0 / 1
  - 0x2f+0x4f -> 0x74 / 0
  - 0x6f+0x00+1 -> 0x76 / 0
- Decimal subtract, dsa=1, b=~operand, result sb_ac / acr:
  - 0x00-0x00 with c=0 -> 0x99 / 0
  - 0x00-0x00 with c=1 -> 0x00 / 1
  - 0x00-0x01 with c=1 -> 0x99 / 0
  - 0x0b-0x00 with c=0 -> 0x0a / 1
  - 0x9a-0x00 with c=1 -> 0x9a / 1
- Op-select corners: no select -> 0x00, all flags 0. sums+ands both set -> sum result. daa+dsa both set -> add-adjust behaviour.
- Latency: change inputs between edges -> outputs unchanged until next rising clk.
